// File: rtl/atomic_read_arbiter.sv
// Two-requester round-robin front end that reads a 64-bit counter over a 32-bit port
// as an atomic low/high beat pair and returns the assembled value to the winner.
module atomic_read_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  rd_req_i,
    output logic [1:0]  rd_valid_o,
    output logic        rd_err_o,
    output logic [63:0] rd_data_o,
    output logic        cnt_req_o,
    output logic        cnt_atomic_o,
    input  logic        cnt_ack_i,
    input  logic [31:0] cnt_count_i,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StReqLo,
        StReqHi,
        StWaitHi,
        StResp,
        StErr
    } state_e;

    state_e      state_q;
    logic        grant_q;
    logic        last_grant_q;
    logic [31:0] low_q;
    logic [31:0] high_q;
    logic        data_en_q;
    logic        win;
    logic [1:0]  grant_vec;

    // A lone requester always wins; on a tie the one not served last time wins.
    always_comb begin
        win = 1'b0;
        if (rd_req_i == 2'b10) begin
            win = 1'b1;
        end else if (rd_req_i == 2'b11) begin
            win = ~last_grant_q;
        end
    end

    assign grant_vec = grant_q ? 2'b10 : 2'b01;

    // Only flop outputs feed this gate, so the data bus stays zero except during RESP.
    assign rd_data_o = data_en_q ? {high_q, low_q} : 64'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            low_q        <= 32'd0;
            high_q       <= 32'd0;
            data_en_q    <= 1'b0;
            rd_valid_o   <= 2'b00;
            rd_err_o     <= 1'b0;
            cnt_req_o    <= 1'b0;
            cnt_atomic_o <= 1'b0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            rd_valid_o   <= 2'b00;
            rd_err_o     <= 1'b0;
            data_en_q    <= 1'b0;
            cnt_req_o    <= 1'b0;
            cnt_atomic_o <= 1'b0;
            busy_o       <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (|rd_req_i) begin
                        state_q      <= StReqLo;
                        grant_q      <= win;
                        last_grant_q <= win;
                        cnt_req_o    <= 1'b1;
                        cnt_atomic_o <= 1'b1;
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                StReqLo: begin
                    state_q   <= StReqHi;
                    cnt_req_o <= 1'b1;
                end
                StReqHi: begin
                    if (cnt_ack_i) begin
                        low_q   <= cnt_count_i;
                        state_q <= StWaitHi;
                    end else begin
                        state_q    <= StErr;
                        rd_valid_o <= grant_vec;
                        rd_err_o   <= 1'b1;
                        err_o      <= 1'b1;
                    end
                end
                StWaitHi: begin
                    if (cnt_ack_i) begin
                        high_q     <= cnt_count_i;
                        state_q    <= StResp;
                        rd_valid_o <= grant_vec;
                        data_en_q  <= 1'b1;
                    end else begin
                        state_q    <= StErr;
                        rd_valid_o <= grant_vec;
                        rd_err_o   <= 1'b1;
                        err_o      <= 1'b1;
                    end
                end
                StResp, StErr: begin
                    state_q <= StIdle;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_o  <= 1'b0;
                end
            endcase
            // An ack with no beat outstanding is a protocol error; it is otherwise ignored.
            if (cnt_ack_i && (state_q == StIdle || state_q == StReqLo || state_q == StResp)) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule
